// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int LARGURA_PADRAO = 16;
  localparam int CONT_W         = $clog2(LARGURA_PADRAO);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    PRONTO = 2'd2
  } estado_t;

endpackage

// File: rtl/multiplicador_seq_if.sv
// ALU-side bus of the multiplier: launch request, operands, product and status.
interface multiplicador_seq_if
  import mult_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  // Handshake: a rising edge of the level signal ini launches one operation
  // unless one is already running; pronto pulses for exactly one cycle when
  // res_low/res_high carry the new product, which then holds until the next
  // completion. ocupado is high while the multiply bits are being retired.
  logic               ini;
  logic [LARGURA-1:0] operando1;
  logic [LARGURA-1:0] operando2;
  logic [LARGURA-1:0] res_low;
  logic [LARGURA-1:0] res_high;
  logic               ocupado;
  logic               pronto;
  estado_t            estado;

  modport master (
    output ini, operando1, operando2,
    input  res_low, res_high, ocupado, pronto, estado
  );

  modport slave (
    input  ini, operando1, operando2,
    output res_low, res_high, ocupado, pronto, estado
  );

endinterface

// File: rtl/multiplicador_seq_detector_borda.sv
// Rising-edge detector for the ALU start level; ini_d resets low so a level
// already high out of reset counts as a start.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic ini,
    output logic inicio
);

    logic ini_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ini_d <= 1'b0;
        end else begin
            ini_d <= ini;
        end
    end

    assign inicio = ini & ~ini_d;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier, one multiplier bit retired per clock.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude core).
module multiplicador_seq
    import mult_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input logic                clock,
    input logic                reset,
    multiplicador_seq_if.slave bus
);

    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

    estado_t               estado;
    estado_t               estado_prox;
    logic                  inicio;
    logic                  carregar;
    logic                  ultimo;
    logic [CW-1:0]         cont;
    logic [LARGURA-1:0]    mcd;
    logic [LARGURA-1:0]    mlt;
    logic [2*LARGURA-1:0]  acc;
    logic [2*LARGURA-1:0]  acc_prox;
    logic [2*LARGURA-1:0]  produto;
    logic [2*LARGURA-1:0]  res;
    logic [LARGURA:0]      soma;
    logic [LARGURA-1:0]    op1_ent;
    logic [LARGURA-1:0]    op2_ent;

    detector_borda u_detector_borda (
        .clock  (clock),
        .reset  (reset),
        .ini    (bus.ini),
        .inicio (inicio)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        carregar    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    carregar    = 1'b1;
                    estado_prox = CALC;
                end
            end
            CALC: begin
                if (ultimo) begin
                    estado_prox = PRONTO;
                end
            end
            PRONTO:  estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    assign ultimo = (cont == CW'(LARGURA - 1));

    // Add into the upper half with one extra carry bit, then shift the
    // whole {carry, acc} right by one.
    assign soma     = {1'b0, acc[2*LARGURA-1:LARGURA]} + {1'b0, (mlt[0] ? mcd : {LARGURA{1'b0}})};
    assign acc_prox = {soma, acc[LARGURA-1:1]};

`ifdef MULT_SIGNED_EN
    logic sinal;

    assign op1_ent = bus.operando1[LARGURA-1] ? -bus.operando1 : bus.operando1;
    assign op2_ent = bus.operando2[LARGURA-1] ? -bus.operando2 : bus.operando2;
    assign produto = sinal ? -acc_prox : acc_prox;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal <= 1'b0;
        end else if (carregar) begin
            sinal <= bus.operando1[LARGURA-1] ^ bus.operando2[LARGURA-1];
        end
    end
`else
    assign op1_ent = bus.operando1;
    assign op2_ent = bus.operando2;
    assign produto = acc_prox;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcd  <= '0;
            mlt  <= '0;
            acc  <= '0;
            cont <= '0;
            res  <= '0;
        end else if (carregar) begin
            mcd  <= op1_ent;
            mlt  <= op2_ent;
            acc  <= '0;
            cont <= '0;
        end else if (estado == CALC) begin
            acc  <= acc_prox;
            mlt  <= mlt >> 1;
            cont <= cont + CW'(1);
            if (ultimo) begin
                res <= produto;
            end
        end
    end

    assign bus.res_low  = res[LARGURA-1:0];
    assign bus.res_high = res[2*LARGURA-1:LARGURA];
    assign bus.ocupado  = (estado == CALC);
    assign bus.pronto   = (estado == PRONTO);
    assign bus.estado   = estado;

endmodule
